// File: rtl/sdm_axil_regs_mc.sv
`default_nettype none
// ============================================================================
// Module   : sdm_axil_regs_mc
// Brief    : AXI4-Lite register bank for NUM_CH sigma-delta modulator
//            channels. It holds a per-channel enable and input value, a
//            read-only ID word and per-channel update strobes.
// Options  : SDM_REG_SHADOW_EN - CTRL/VALUE writes go to shadow registers.
//            A write of 1 to COMMIT (0x08) copies the shadows to the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module sdm_axil_regs_mc #(
  parameter int NUM_CH  = 4,
  parameter int VALUE_W = 16,
  parameter int ADDR_W  = 12
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [31:0]                 awaddr,
  input  logic [2:0]                  awprot,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [31:0]                 wdata,
  input  logic [3:0]                  wstrb,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  input  logic [31:0]                 araddr,
  input  logic [2:0]                  arprot,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [31:0]                 rdata,
  output logic [1:0]                  rresp,
  output logic                        rvalid,
  input  logic                        rready,
  output logic [NUM_CH-1:0]           enable,
  output logic [NUM_CH*VALUE_W-1:0]   value,
  output logic [NUM_CH-1:0]           upd_stb
);

  localparam logic [31:0] C_ID       = 32'h5344_0000 | (32'(NUM_CH) << 8) | 32'(VALUE_W);
  localparam logic [2:0]  C_K_NONE   = 3'd0;
  localparam logic [2:0]  C_K_CTRL   = 3'd1;
  localparam logic [2:0]  C_K_ID     = 3'd2;
  localparam logic [2:0]  C_K_COMMIT = 3'd3;
  localparam logic [2:0]  C_K_VALUE  = 3'd4;
  localparam logic [1:0]  C_OKAY     = 2'b00;
  localparam logic [1:0]  C_SLVERR   = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  // Address decode: returns {kind[2:0], channel index[3:0]}. Misaligned
  // addresses never match a register and fall through to C_K_NONE.
  function automatic logic [6:0] f_decode(input logic [ADDR_W-1:0] a);
    logic [6:0] d;
    d = {C_K_NONE, 4'd0};
    if (a == ADDR_W'(0))
      d = {C_K_CTRL, 4'd0};
    else if (a == ADDR_W'(4))
      d = {C_K_ID, 4'd0};
`ifdef SDM_REG_SHADOW_EN
    else if (a == ADDR_W'(8))
      d = {C_K_COMMIT, 4'd0};
`endif
    for (int n = 0; n < NUM_CH; n++)
      if (a == ADDR_W'(16 + 4 * n))
        d = {C_K_VALUE, 4'(n)};
    return d;
  endfunction

  // Byte-lane merge of new write data over an old register value
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++)
      m[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return m;
  endfunction

  // --------------------------------------------------------------------------
  // Write channel
  // --------------------------------------------------------------------------
  wstate_t             r_wstate;
  wstate_t             w_wstate_nxt;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [1:0]          r_bresp;
  logic [NUM_CH-1:0]   r_upd_stb;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_wr_fire;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [31:0]         w_wr_data;
  logic [3:0]          w_wr_strb;
  logic [6:0]          w_wr_dec;
  logic [2:0]          w_wr_kind;
  logic [3:0]          w_wr_idx;
  logic                w_wr_ok;
  logic [NUM_CH-1:0]   w_en_bus_in;
  logic [NUM_CH-1:0]   r_en_bus;
  logic [VALUE_W-1:0]  r_val_bus [NUM_CH];
  logic [31:0]         w_val_old;
  logic [31:0]         w_ctrl_merged;
  logic [31:0]         w_val_merged;
  logic [NUM_CH-1:0]   w_ctrl_lane;
  logic [NUM_CH-1:0]   w_upd_nxt;

  assign awready = aresetn && ((r_wstate == W_IDLE) || (r_wstate == W_DATA));
  assign wready  = aresetn && ((r_wstate == W_IDLE) || (r_wstate == W_ADDR));
  assign bvalid  = (r_wstate == W_RESP);
  assign bresp   = r_bresp;
  assign upd_stb = r_upd_stb;
  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;

  // The half of the transaction captured earlier comes from the holding regs
  assign w_wr_addr = (r_wstate == W_ADDR) ? r_awaddr : awaddr[ADDR_W-1:0];
  assign w_wr_data = (r_wstate == W_DATA) ? r_wdata  : wdata;
  assign w_wr_strb = (r_wstate == W_DATA) ? r_wstrb  : wstrb;
  assign w_wr_dec  = f_decode(w_wr_addr);
  assign w_wr_kind = w_wr_dec[6:4];
  assign w_wr_idx  = w_wr_dec[3:0];
  assign w_wr_ok   = (w_wr_kind != C_K_NONE) && (w_wr_kind != C_K_ID);
  assign w_en_bus_in = r_en_bus;

  // Write FSM next state; w_wr_fire marks the edge entering W_RESP
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_fire    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wstate_nxt = W_RESP;
          w_wr_fire    = 1'b1;
        end else if (w_aw_hs) begin
          w_wstate_nxt = W_ADDR;
        end else if (w_w_hs) begin
          w_wstate_nxt = W_DATA;
        end
      end
      W_ADDR: begin
        if (w_w_hs) begin
          w_wstate_nxt = W_RESP;
          w_wr_fire    = 1'b1;
        end
      end
      W_DATA: begin
        if (w_aw_hs) begin
          w_wstate_nxt = W_RESP;
          w_wr_fire    = 1'b1;
        end
      end
      W_RESP: begin
        if (bready)
          w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Old value of the addressed channel and the byte-merged results
  always_comb begin
    w_val_old = 32'd0;
    for (int n = 0; n < NUM_CH; n++)
      if (w_wr_idx == 4'(n))
        w_val_old = 32'(r_val_bus[n]);
    w_ctrl_merged = f_merge(32'(w_en_bus_in), w_wr_data, w_wr_strb);
    w_val_merged  = f_merge(w_val_old, w_wr_data, w_wr_strb);
    for (int n = 0; n < NUM_CH; n++)
      w_ctrl_lane[n] = w_wr_strb[n / 8];
  end

`ifdef SDM_REG_SHADOW_EN
  logic                w_commit;
  logic [NUM_CH-1:0]   r_en_live;
  logic [VALUE_W-1:0]  r_val_live [NUM_CH];

  assign w_commit = w_wr_fire && (w_wr_kind == C_K_COMMIT) && w_wr_data[0] && w_wr_strb[0];
  assign enable   = r_en_live;

  // A commit copies every shadow to the live outputs at once
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_en_live <= '0;
      for (int n = 0; n < NUM_CH; n++)
        r_val_live[n] <= '0;
    end else if (w_commit) begin
      r_en_live <= r_en_bus;
      for (int n = 0; n < NUM_CH; n++)
        r_val_live[n] <= r_val_bus[n];
    end
  end

  // Every channel is strobed on a commit
  always_comb begin
    w_upd_nxt = '0;
    if (w_commit)
      w_upd_nxt = '1;
  end
`else
  assign enable = r_en_bus;

  // Strobe the channels touched by this write
  always_comb begin
    w_upd_nxt = '0;
    if (w_wr_fire && (w_wr_kind == C_K_CTRL))
      w_upd_nxt = w_ctrl_lane;
    for (int n = 0; n < NUM_CH; n++)
      if (w_wr_fire && (w_wr_kind == C_K_VALUE) && (w_wr_idx == 4'(n)))
        w_upd_nxt[n] = 1'b1;
  end
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_value
`ifdef SDM_REG_SHADOW_EN
    assign value[gi*VALUE_W +: VALUE_W] = r_val_live[gi];
`else
    assign value[gi*VALUE_W +: VALUE_W] = r_val_bus[gi];
`endif
  end

  // Write FSM state, half-transaction holding registers and response
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wstate  <= W_IDLE;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= C_OKAY;
      r_upd_stb <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_upd_stb <= w_upd_nxt;
      if (w_aw_hs)
        r_awaddr <= awaddr[ADDR_W-1:0];
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_wr_fire)
        r_bresp <= w_wr_ok ? C_OKAY : C_SLVERR;
    end
  end

  // Bus-visible CTRL/VALUE registers (shadows when the shadow option is on)
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_en_bus <= '0;
      for (int n = 0; n < NUM_CH; n++)
        r_val_bus[n] <= '0;
    end else if (w_wr_fire) begin
      if (w_wr_kind == C_K_CTRL)
        r_en_bus <= w_ctrl_merged[NUM_CH-1:0];
      for (int n = 0; n < NUM_CH; n++)
        if ((w_wr_kind == C_K_VALUE) && (w_wr_idx == 4'(n)))
          r_val_bus[n] <= w_val_merged[VALUE_W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Read channel
  // --------------------------------------------------------------------------
  rstate_t       r_rstate;
  rstate_t       w_rstate_nxt;
  logic          w_ar_hs;
  logic [6:0]    w_rd_dec;
  logic [31:0]   w_rd_data;
  logic [1:0]    w_rd_resp;
  logic [31:0]   r_rdata;
  logic [1:0]    r_rresp;

  assign arready  = aresetn && (r_rstate == R_IDLE);
  assign rvalid   = (r_rstate == R_DATA);
  assign rdata    = r_rdata;
  assign rresp    = r_rresp;
  assign w_ar_hs  = arvalid && arready;
  assign w_rd_dec = f_decode(araddr[ADDR_W-1:0]);

  // Read data mux; unmapped addresses return zero with SLVERR
  always_comb begin
    w_rd_data = 32'd0;
    w_rd_resp = C_OKAY;
    case (w_rd_dec[6:4])
      C_K_CTRL:   w_rd_data = 32'(r_en_bus);
      C_K_ID:     w_rd_data = C_ID;
      C_K_COMMIT: w_rd_data = 32'd0;
      C_K_VALUE: begin
        for (int n = 0; n < NUM_CH; n++)
          if (w_rd_dec[3:0] == 4'(n))
            w_rd_data = 32'(r_val_bus[n]);
      end
      default:    w_rd_resp = C_SLVERR;
    endcase
  end

  // Read FSM next state
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (rready)  w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read state and response registers; data is sampled at the ar handshake
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= C_OKAY;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
      end
    end
  end

  // Ignored inputs and intentionally partial-width intermediates
  logic w_unused;
  assign w_unused = &{1'b0, awprot, arprot, awaddr[31:ADDR_W], araddr[31:ADDR_W],
                      w_ctrl_merged, w_val_merged, w_ctrl_lane};

endmodule
`default_nettype wire
